fir_filter_mc: RTL and testbench

- Parametrised, multi-channel, time-multiplexed FIR filter for the IQ demodulator datapath. Successor to the fixed 5-bit single-channel filter.
- Takes one signed sample per channel per input handshake (I/Q pair by default). Runs every channel through a shared delay-line/coefficient set using one multiplier-accumulator.
- Outputs scaled, saturated results on a valid/ready interface. Sits between the ADC-enable/valid logic and the downstream demodulator.

---
 rtl/fir_filter_mc.sv | 150 +++++++++++++++
 tb/tb_fir_filter_mc.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_mc.sv
// Multi-channel time-multiplexed FIR: one shared MAC walks every channel's delay line in turn.
// Define FIR_COEF_WR_EN to make coefficients writable; otherwise every tap is the constant COEF_RST.
module fir_filter_mc #(
    parameter int DATA_W   = 5,
    parameter int COEF_W   = 8,
    parameter int NTAPS    = 8,
    parameter int NCH      = 2,
    parameter int SHIFT    = 3,
    parameter int COEF_RST = 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NCH*DATA_W-1:0]     in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NCH*DATA_W-1:0]     out_data,
    input  logic                      coef_we,
    input  logic [$clog2(NTAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]         coef_data
);
    localparam int AW    = $clog2(NTAPS);
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW    = DATA_W + COEF_W;
    localparam int ACC_W = PW + AW;
    localparam int SMAX  = (1 << (DATA_W - 1)) - 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(SMAX);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-SMAX - 1);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
    state_t state_q, state_d;

    logic signed [DATA_W-1:0] taps [NCH][NTAPS];
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [PW-1:0]     prod;
    logic signed [COEF_W-1:0] coef_sel;
    logic [AW-1:0]            tap_cnt;
    logic [CW-1:0]            ch_cnt;
    logic                     last_tap, last_ch, accept;

    function automatic logic signed [DATA_W-1:0] sat_shift(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> SHIFT;
        if (s > SAT_MAX)
            s = SAT_MAX;
        else if (s < SAT_MIN)
            s = SAT_MIN;
        return s[DATA_W-1:0];
    endfunction

`ifdef FIR_COEF_WR_EN
    logic signed [COEF_W-1:0] coefs [NTAPS];

    // Writes land only while idle, so a running computation never sees a coefficient change.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < NTAPS; k++)
                coefs[k] <= COEF_W'(COEF_RST);
        end else if (!clear && state_q == IDLE && coef_we && 32'(coef_addr) < NTAPS) begin
            coefs[coef_addr] <= coef_data;
        end
    end

    assign coef_sel = coefs[tap_cnt];
`else
    logic unused_coef;
    assign unused_coef = ^{coef_we, coef_addr, coef_data};
    assign coef_sel    = COEF_W'(COEF_RST);
`endif

    assign last_tap = (tap_cnt == AW'(NTAPS - 1));
    assign last_ch  = (ch_cnt == CW'(NCH - 1));
    assign accept   = in_ready & in_valid & ~clear;
    assign prod     = PW'(taps[ch_cnt][tap_cnt]) * PW'(coef_sel);
    assign acc_sum  = acc + ACC_W'(prod);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_d = MAC;
            end
            MAC: begin
                if (last_tap && last_ch)
                    state_d = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clear)
            state_d = IDLE;
    end

    // Channel-major walk: all taps of one channel, write its result, then move to the next.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int c = 0; c < NCH; c++)
                for (int k = 0; k < NTAPS; k++)
                    taps[c][k] <= '0;
            acc      <= '0;
            tap_cnt  <= '0;
            ch_cnt   <= '0;
            out_data <= '0;
        end else if (clear) begin
            for (int c = 0; c < NCH; c++)
                for (int k = 0; k < NTAPS; k++)
                    taps[c][k] <= '0;
            acc     <= '0;
            tap_cnt <= '0;
            ch_cnt  <= '0;
        end else if (accept) begin
            for (int c = 0; c < NCH; c++) begin
                taps[c][0] <= in_data[c*DATA_W +: DATA_W];
                for (int k = 1; k < NTAPS; k++)
                    taps[c][k] <= taps[c][k-1];
            end
            acc     <= '0;
            tap_cnt <= '0;
            ch_cnt  <= '0;
        end else if (state_q == MAC) begin
            if (last_tap) begin
                out_data[ch_cnt*DATA_W +: DATA_W] <= sat_shift(acc_sum);
                acc     <= '0;
                tap_cnt <= '0;
                ch_cnt  <= last_ch ? '0 : ch_cnt + CW'(1);
            end else begin
                acc     <= acc_sum;
                tap_cnt <= tap_cnt + AW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fir_filter_mc.sv
// Directed bench for fir_filter_mc: impulse, step, saturation, backpressure, clear and async reset.
module tb_fir_filter_mc;
    localparam int DATA_W = 5;
    localparam int NCH    = 2;

    logic              clk = 1'b0;
    logic              resetn, clear, in_valid, in_ready, out_valid, out_ready, coef_we;
    logic [NCH*DATA_W-1:0] in_data, out_data;
    logic [2:0]        coef_addr;
    logic [7:0]        coef_data;

    int n_chk = 0;
    int n_err = 0;
    int exp0 [9] = '{0, 0, 1, 1, 1, 2, 2, 3, 3};
    int exp1 [9] = '{-1, -2, -2, -3, -4, -4, -5, -5, -5};

    fir_filter_mc dut (
        .clk(clk), .resetn(resetn), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ch(input int c);
        logic signed [DATA_W-1:0] v;
        v = out_data[c*DATA_W +: DATA_W];
        return int'(v);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; in_valid = 1'b0; clear = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic wait_vld(input string tag);
        int w = 0;
        while (!out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk(tag, int'(out_valid), 1);
    endtask

    task automatic run(input int d0, input int d1, output int o0, output int o1, output int lat);
        int w = 0;
        @(negedge clk);
        in_data  = {5'(d1), 5'(d0)};
        in_valid = 1'b1;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("accept_rdy", int'(in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        coef_we  = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        o0 = ch(0);
        o1 = ch(1);
    endtask

    task automatic step(input string tag, input int d0, input int d1, input int e0, input int e1);
        int o0, o1, lat;
        run(d0, d1, o0, o1, lat);
        chk({tag, "_lat"}, lat, 16);
        chk({tag, "_ch0"}, o0, e0);
        chk({tag, "_ch1"}, o1, e1);
    endtask

    task automatic wcoef(input int a, input int d);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = 3'(a); coef_data = 8'(d);
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        resetn = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        #2 resetn = 1'b0;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        @(negedge clk);
        resetn = 1'b1;

        step("dirac0", 8, 0, 1, 0);
        for (int i = 1; i < 8; i++)
            step($sformatf("dirac%0d", i), 0, 0, 1, 0);
        step("dirac8", 0, 0, 0, 0);

        do_reset();
        for (int i = 0; i < 9; i++)
            step($sformatf("step%0d", i), 3, -5, exp0[i], exp1[i]);

        do_reset();
        @(negedge clk);
        in_data = {5'd0, 5'd8}; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        wait_vld("bp_vld_rise");
        in_data = {5'd0, 5'd15}; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_ch0", ch(0), 1);
            @(negedge clk);
        end
        out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("bp_rel_rdy", int'(in_ready), 1);
        chk("bp_rel_vld", int'(out_valid), 0);
        step("bp_hist", 0, 0, 1, 0);

        @(negedge clk);
        in_data = {5'd0, 5'd8}; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_in_ready", int'(in_ready), 1);
        chk("clr_keep_ch0", ch(0), 1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("clr_no_valid", seen, 0);
        step("clr_flush", 8, 0, 1, 0);

`ifdef FIR_COEF_WR_EN
        wcoef(0, 127);
        for (int k = 1; k < 8; k++)
            wcoef(k, 0);
        step("sat_pos", 15, 0, 15, 0);
        step("sat_neg", -16, 0, -16, 0);
        @(negedge clk);
        in_data = {5'd0, 5'd1}; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; coef_we = 1'b1; coef_addr = 3'd0; coef_data = 8'd1;
        repeat (10) @(negedge clk);
        coef_we = 1'b0;
        wait_vld("macwr_vld");
        chk("macwr_ch0", ch(0), 15);
        step("macwr_after", 1, 0, 15, 0);
        coef_we = 1'b1; coef_addr = 3'd0; coef_data = 8'd64;
        step("wr_accept", 1, 0, 8, 0);
`else
        coef_we = 1'b1; coef_addr = 3'd0; coef_data = 8'd127;
        step("wr_ignored", 8, 0, 2, 0);
`endif

        out_ready = 1'b0;
        @(negedge clk);
        in_data = {5'(-5), 5'd3}; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_vld("ar_pre_vld");
        #1 resetn = 1'b0;
        #1;
        chk("ar_out_valid", int'(out_valid), 0);
        chk("ar_in_ready", int'(in_ready), 1);
        chk("ar_out_data", int'(out_data), 0);
        @(negedge clk);
        resetn = 1'b1; out_ready = 1'b1;
        step("ar_step0", 3, -5, 0, -1);
        step("ar_step1", 3, -5, 0, -2);
        step("ar_step2", 3, -5, 1, -2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
